ins_packer: RTL and testbench
=============================

INS_PACKER -- requirements
Module: ins_packer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: mid-frame idle cycles before frame abort; 0 disables timeout.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_data  input  8  byte beat.
REQ-005 in_valid  input  1  in_data valid.
REQ-006 in_first  input  1  marks beat 0 of a frame; qualified by in_valid.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 ins  output  65  packed operand bus: [7:0] s1.x, [15:8] s1.y, [23:16] s1.z, [31:24] s1.w, [32] cin, [40:33] s2.x, [48:41] s2.y, [56:49] s2.z, [64:57] s2.w.
REQ-009 out_valid  output  1  ins/chk hold a complete frame.
REQ-010 out_ready  input  1  downstream consumes frame.
REQ-011 chk  output  10  expected adder sum of the presented frame.
REQ-012 err  output  1  one-cycle protocol-error pulse.
REQ-013 frame_cnt  output  16  count of delivered frames.

Function
REQ-014 Beat accepted when in_valid && in_ready at a rising edge.
REQ-015 Frame = 9 beats in order: s1.x, s1.y, s1.z, s1.w, s2.x, s2.y, s2.z, s2.w, cin; cin = in_data[0], in_data[7:1] ignored.
REQ-016 States: IDLE (expect beat 0), COLLECT (beats 1..8), FULL (presenting).
REQ-017 in_ready = 1 in IDLE and COLLECT, 0 in FULL.
REQ-018 IDLE: accepted beat with in_first=1 stores beat 0, beat index 1, go COLLECT.
REQ-019 IDLE: accepted beat with in_first=0 discarded, err pulses next cycle, stay IDLE.
REQ-020 COLLECT: accepted beat with in_first=0 stored at current index; after beat 8 (cin) go FULL.
REQ-021 COLLECT: accepted beat with in_first=1 restarts frame (stored as beat 0, index 1), err pulses, partial data discarded.
REQ-022 chk accumulated per beat: chk = (sum of eight bytes + cin) mod 1024, i.e. 10-bit truncation identical to the adder sm width.
REQ-023 FULL: out_valid=1; ins and chk stable until out_ready=1; on out_valid && out_ready go IDLE, out_valid=0 next cycle, frame_cnt +1 (wraps 0xFFFF->0).
REQ-024 Latency: out_valid asserted the cycle after the cin beat is accepted; min frame period 10 cycles (9 beats + FULL cycle with out_ready=1).
REQ-025 Timeout: idle counter in COLLECT counts cycles without an accepted beat, clears on each accepted beat; reaching TIMEOUT_CYCLES -> frame discarded, go IDLE, err pulses; inactive when TIMEOUT_CYCLES=0 and in IDLE/FULL.
REQ-026 ins bits not yet written in current frame hold 0 (cleared on frame start).
REQ-027 err is a single-cycle pulse per event; simultaneous events yield one pulse.
REQ-028 Beats presented in FULL are not accepted (in_ready=0) and not flagged.

Reset
REQ-029 rst_n=0 at rising edge: state IDLE, ins=0, chk=0, out_valid=0, err=0, frame_cnt=0, beat index 0, idle counter 0; in_ready=1 once rst_n=1.
REQ-030 Reset mid-frame or in FULL discards the frame with no err pulse and no frame_cnt increment.

Verification
REQ-031 Frame 01,02,03,04,05,06,07,08, cin=01 -> ins fields match, chk=37 (0x025), out_valid one cycle after cin beat, frame_cnt=1 after out_ready.
REQ-032 All bytes FF, cin=1 -> chk = 2041 mod 1024 = 1017 (0x3F9).
REQ-033 in_first=1 at beat 4 -> err pulse, new frame starts; following 8 beats complete it with chk of new frame only.
REQ-034 TIMEOUT_CYCLES=4, stop after beat 3 -> err pulse after 4 idle cycles, state IDLE, next in_first frame completes normally.
REQ-035 out_ready held 0 for 20 cycles in FULL -> ins/chk stable, in_ready=0, in_valid beats ignored; out_ready=1 -> IDLE next cycle.
REQ-036 rst_n=0 for one edge after beat 5 -> all outputs 0, no err; fresh frame then delivers correctly, frame_cnt=1.

Source files
------------

// File: rtl/ins_packer_if.sv
// Byte-beat input stream and packed-operand output bus of the instruction packer.
interface ins_packer_if;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_first;
   logic        in_ready;
   logic [64:0] ins;
   logic        out_valid;
   logic        out_ready;
   logic [9:0]  chk;
   logic        err;
   logic [15:0] frame_cnt;

   modport master (
      output in_data, in_valid, in_first, out_ready,
      input  in_ready, ins, out_valid, chk, err, frame_cnt
   );

   modport slave (
      input  in_data, in_valid, in_first, out_ready,
      output in_ready, ins, out_valid, chk, err, frame_cnt
   );
endinterface

// File: rtl/ins_packer.sv
// Collects nine byte beats into a 65-bit adder operand word and its expected
// 10-bit sum, presents the frame until consumed, and flags protocol errors.
module ins_packer #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic         clk,
   input  logic         rst_n,
   ins_packer_if.slave  bus
);

   localparam int unsigned DATA_W = 8;
   localparam int unsigned INS_W  = 65;
   localparam int unsigned CHK_W  = 10;
   localparam int unsigned CNT_W  = 16;
   localparam int unsigned IDX_W  = 4;
   localparam int unsigned TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_COLLECT = 2'd1;
   localparam logic [1:0] S_FULL    = 2'd2;

   localparam logic [IDX_W-1:0] IDX_CIN = IDX_W'(8);

   logic [1:0]       state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [INS_W-1:0] ins_q, ins_d;
   logic [CHK_W-1:0] chk_q, chk_d;
   logic [TMO_W-1:0] idle_q, idle_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             out_valid_q, out_valid_d;
   logic             in_ready_q, in_ready_d;

   logic             accept_c;
   logic [TMO_W-1:0] idle_inc_c;

   assign accept_c   = bus.in_valid && in_ready_q;
   assign idle_inc_c = idle_q + TMO_W'(1);

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      ins_d   = ins_q;
      chk_d   = chk_q;
      idle_d  = idle_q;
      cnt_d   = cnt_q;
      err_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            idle_d = '0;
            if (accept_c) begin
               if (bus.in_first) begin
                  ins_d        = '0;
                  ins_d[7:0]   = bus.in_data;
                  chk_d        = CHK_W'(bus.in_data);
                  idx_d        = IDX_W'(1);
                  state_d      = S_COLLECT;
               end else begin
                  err_d = 1'b1;
               end
            end
         end

         S_COLLECT: begin
            if (accept_c) begin
               idle_d = '0;
               if (bus.in_first) begin
                  // Restart: partial frame is dropped, new beat becomes beat 0.
                  ins_d      = '0;
                  ins_d[7:0] = bus.in_data;
                  chk_d      = CHK_W'(bus.in_data);
                  idx_d      = IDX_W'(1);
                  err_d      = 1'b1;
               end else begin
                  case (idx_q)
                     IDX_W'(1): ins_d[15:8]  = bus.in_data;
                     IDX_W'(2): ins_d[23:16] = bus.in_data;
                     IDX_W'(3): ins_d[31:24] = bus.in_data;
                     IDX_W'(4): ins_d[40:33] = bus.in_data;
                     IDX_W'(5): ins_d[48:41] = bus.in_data;
                     IDX_W'(6): ins_d[56:49] = bus.in_data;
                     IDX_W'(7): ins_d[64:57] = bus.in_data;
                     IDX_W'(8): ins_d[32]    = bus.in_data[0];
                     default:   ins_d        = ins_q;
                  endcase
                  if (idx_q == IDX_CIN) begin
                     chk_d   = chk_q + CHK_W'(bus.in_data[0]);
                     idx_d   = '0;
                     state_d = S_FULL;
                  end else begin
                     chk_d   = chk_q + CHK_W'(bus.in_data);
                     idx_d   = idx_q + IDX_W'(1);
                  end
               end
            end else if (TIMEOUT_CYCLES != 0) begin
               if (idle_inc_c == TMO_W'(TIMEOUT_CYCLES)) begin
                  idle_d  = '0;
                  idx_d   = '0;
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  idle_d = idle_inc_c;
               end
            end
         end

         S_FULL: begin
            idle_d = '0;
            if (bus.out_ready) begin
               cnt_d   = cnt_q + CNT_W'(1);
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
            idx_d   = '0;
            idle_d  = '0;
         end
      endcase

      in_ready_d  = (state_d != S_FULL);
      out_valid_d = (state_d == S_FULL);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         ins_q       <= '0;
         chk_q       <= '0;
         idle_q      <= '0;
         cnt_q       <= '0;
         err_q       <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         ins_q       <= ins_d;
         chk_q       <= chk_d;
         idle_q      <= idle_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.ins       = ins_q;
   assign bus.chk       = chk_q;
   assign bus.out_valid = out_valid_q;
   assign bus.err       = err_q;
   assign bus.frame_cnt = cnt_q;

endmodule

// File: tb/tb_ins_packer.sv
// Directed bench for ins_packer: frame-level reference model compared every
// cycle, plus hand-computed literal checks on key frames.
module tb_ins_packer;

   localparam int TO = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ins_packer_if bus();

   ins_packer #(.TIMEOUT_CYCLES(TO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int vectors = 0;
   int miscompares = 0;
   bit cmp_en = 1'b0;

   // Reference: bytes received so far in the current frame, beat count, error flag.
   logic [7:0]  mb [9];
   int          mn = 0;
   int          midle = 0;
   logic        merr = 1'b0;
   logic [15:0] mcnt = '0;

   task automatic check(input string nm, input logic [64:0] act, input logic [64:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: actual=%h expected=%h", nm, $time, act, exp);
      end
   endtask

   function automatic logic [64:0] exp_ins();
      return {mb[7], mb[6], mb[5], mb[4], mb[8][0], mb[3], mb[2], mb[1], mb[0]};
   endfunction

   function automatic logic [9:0] exp_chk();
      int s = 0;
      for (int i = 0; i < 8; i++) s += int'(mb[i]);
      s += int'(mb[8][0]);
      return 10'(s % 1024);
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         mn = 0; midle = 0; merr = 1'b0; mcnt = '0;
         for (int i = 0; i < 9; i++) mb[i] = 8'h00;
      end else begin
         merr = 1'b0;
         if (mn == 9) begin
            if (bus.out_ready) begin
               mn = 0;
               mcnt = mcnt + 16'd1;
            end
         end else if (bus.in_valid) begin
            midle = 0;
            if (bus.in_first) begin
               merr = (mn != 0);
               for (int i = 0; i < 9; i++) mb[i] = 8'h00;
               mb[0] = bus.in_data;
               mn = 1;
            end else if (mn == 0) begin
               merr = 1'b1;
            end else begin
               mb[mn] = (mn == 8) ? {7'b0, bus.in_data[0]} : bus.in_data;
               mn++;
            end
         end else if (mn > 0) begin
            midle++;
            if (midle == TO) begin
               mn = 0; midle = 0; merr = 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("in_ready",  65'(bus.in_ready),  65'(mn != 9));
         check("out_valid", 65'(bus.out_valid), 65'(mn == 9));
         check("ins",       bus.ins,            exp_ins());
         check("chk",       65'(bus.chk),       65'(exp_chk()));
         check("err",       65'(bus.err),       65'(merr));
         check("frame_cnt", 65'(bus.frame_cnt), 65'(mcnt));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d, input logic f);
      bus.in_data  = d;
      bus.in_first = f;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      bus.in_first = 1'b0;
   endtask

   // f[7:0] is beat 0 (s1.x), f[71:64] is the cin beat.
   task automatic send_frame(input logic [71:0] f);
      for (int i = 0; i < 9; i++) send(f[8*i +: 8], logic'(i == 0));
   endtask

   task automatic consume();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   initial begin
      bus.in_data = '0; bus.in_valid = 1'b0; bus.in_first = 1'b0; bus.out_ready = 1'b0;
      repeat (3) tick();
      check("rst_ins",   bus.ins, 65'd0);
      check("rst_chk",   65'(bus.chk), 65'd0);
      check("rst_oval",  65'(bus.out_valid), 65'd0);
      check("rst_err",   65'(bus.err), 65'd0);
      check("rst_cnt",   65'(bus.frame_cnt), 65'd0);
      rst_n = 1'b1;
      cmp_en = 1'b1;
      tick();
      check("rst_inrdy", 65'(bus.in_ready), 65'd1);

      // Basic frame 01..08, cin=1
      send_frame({8'h01, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01});
      check("f1_oval", 65'(bus.out_valid), 65'd1);
      check("f1_chk",  65'(bus.chk), 65'h025);
      check("f1_ins",  bus.ins, {8'h08, 8'h07, 8'h06, 8'h05, 1'b1, 8'h04, 8'h03, 8'h02, 8'h01});
      consume();
      check("f1_oval_off", 65'(bus.out_valid), 65'd0);
      check("f1_cnt",      65'(bus.frame_cnt), 65'd1);

      // All ones: sum truncates to 10 bits
      send_frame({9{8'hFF}});
      check("ff_chk", 65'(bus.chk), 65'h3F9);
      consume();
      check("ff_cnt", 65'(bus.frame_cnt), 65'd2);

      // Back-pressure for 20 cycles while junk beats arrive
      send_frame({8'h00, 8'h80, 8'h70, 8'h60, 8'h50, 8'h40, 8'h30, 8'h20, 8'h10});
      for (int i = 0; i < 20; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 8'(i * 7);
         bus.in_first = logic'(i % 2);
         tick();
      end
      bus.in_valid = 1'b0; bus.in_first = 1'b0;
      check("bp_chk",   65'(bus.chk), 65'h240);
      check("bp_inrdy", 65'(bus.in_ready), 65'd0);
      check("bp_err",   65'(bus.err), 65'd0);
      consume();
      check("bp_idle",  65'(bus.in_ready), 65'd1);
      check("bp_cnt",   65'(bus.frame_cnt), 65'd3);

      // Restart at beat 4
      send(8'hA0, 1'b1); send(8'hA1, 1'b0); send(8'hA2, 1'b0); send(8'hA3, 1'b0);
      send(8'h11, 1'b1);
      check("rs_err", 65'(bus.err), 65'd1);
      for (int i = 0; i < 7; i++) send(8'(8'h12 + i), 1'b0);
      send(8'h01, 1'b0);
      check("rs_chk", 65'(bus.chk), 65'h0A5);
      check("rs_s1x", 65'(bus.ins[7:0]), 65'h11);
      consume();

      // Stray non-first beat in IDLE
      send(8'h55, 1'b0);
      check("stray_err", 65'(bus.err), 65'd1);
      tick();
      check("stray_err_off", 65'(bus.err), 65'd0);

      // Timeout after four idle cycles
      send(8'h21, 1'b1); send(8'h22, 1'b0); send(8'h23, 1'b0); send(8'h24, 1'b0);
      repeat (3) tick();
      check("to_early_err", 65'(bus.err), 65'd0);
      tick();
      check("to_err", 65'(bus.err), 65'd1);
      tick();
      check("to_err_off", 65'(bus.err), 65'd0);
      send_frame({8'h00, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01});
      check("to_next_chk", 65'(bus.chk), 65'h024);
      consume();
      check("to_cnt", 65'(bus.frame_cnt), 65'd5);

      // Reset mid-frame
      for (int i = 0; i < 6; i++) send(8'(8'h30 + i), logic'(i == 0));
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("mr_ins",  bus.ins, 65'd0);
      check("mr_chk",  65'(bus.chk), 65'd0);
      check("mr_err",  65'(bus.err), 65'd0);
      check("mr_cnt",  65'(bus.frame_cnt), 65'd0);
      check("mr_oval", 65'(bus.out_valid), 65'd0);
      send_frame({8'h01, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01});
      check("mr_chk2", 65'(bus.chk), 65'h025);
      consume();
      check("mr_cnt2", 65'(bus.frame_cnt), 65'd1);

      repeat (2) tick();
      cmp_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
